// File: rtl/fft_frame_sink.sv
// Ping-pong frame collector for the FFT core output, replayed over valid/ready with bin index and last flag.
// Optional FFT_SINK_DROP_CNT_EN adds a saturating dropped-frame counter on o_DROP_CNT.
module fft_frame_sink #(
  parameter int DWL = 16,
  parameter int AWL = 5
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic [DWL-1:0] i_DATA_R,
  input  logic [DWL-1:0] i_DATA_I,
  input  logic           i_VALID,
  output logic [DWL-1:0] o_DATA_R,
  output logic [DWL-1:0] o_DATA_I,
  output logic [AWL-1:0] o_INDEX,
  output logic           o_LAST,
  output logic           o_VALID,
  input  logic           i_READY,
  output logic           o_OVERFLOW
`ifdef FFT_SINK_DROP_CNT_EN
  ,
  output logic [7:0]     o_DROP_CNT
`endif
);

  localparam int N = 1 << AWL;
  localparam logic [AWL-1:0] LAST_IDX = AWL'(N - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

  // Both frames live in one array addressed as {bank, index}
  logic [2*DWL-1:0] mem [0:2*N-1];

  logic           wr_bank_reg;
  logic [AWL-1:0] wr_idx_reg;
  logic           drop_reg;
  logic [1:0]     full_reg;
  logic [1:0]     full_next;
  logic           overflow_reg;

  state_t         state_reg;
  state_t         state_next;
  logic           rd_bank_reg;
  logic [AWL-1:0] rd_idx_reg;
  logic [2*DWL-1:0] rd_data_reg;

  logic accept;
  logic wr_start;
  logic drop_now;
  logic drop_start;
  logic wr_en;
  logic frame_done;
  logic handshake;
  logic rd_done;

  assign accept     = EN & i_VALID;
  assign wr_start   = accept & (wr_idx_reg == '0);
  // The drop decision is made at index 0 from the pre-update full flag and held for the frame
  assign drop_now   = (wr_idx_reg == '0) ? full_reg[wr_bank_reg] : drop_reg;
  assign drop_start = wr_start & full_reg[wr_bank_reg];
  assign wr_en      = accept & ~drop_now;
  assign frame_done = wr_en & (wr_idx_reg == LAST_IDX);
  assign handshake  = (state_reg == PRESENT) & i_READY;
  assign rd_done    = handshake & (rd_idx_reg == LAST_IDX);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_full
      assign full_next[gi] = (rd_done && rd_bank_reg == 1'(gi)) ? 1'b0 :
                             (frame_done && wr_bank_reg == 1'(gi)) ? 1'b1 :
                             full_reg[gi];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_bank_reg  <= 1'b0;
      wr_idx_reg   <= '0;
      drop_reg     <= 1'b0;
      full_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      full_reg <= full_next;
      if (accept) begin
        wr_idx_reg <= wr_idx_reg + AWL'(1);
        if (wr_idx_reg == '0)
          drop_reg <= full_reg[wr_bank_reg];
      end
      if (frame_done)
        wr_bank_reg <= ~wr_bank_reg;
      if (drop_start)
        overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en)
      mem[{wr_bank_reg, wr_idx_reg}] <= {i_DATA_R, i_DATA_I};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      rd_bank_reg <= 1'b0;
      rd_idx_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && full_reg[rd_bank_reg])
        rd_idx_reg <= '0;
      else if (handshake)
        rd_idx_reg <= rd_idx_reg + AWL'(1);
      if (rd_done)
        rd_bank_reg <= ~rd_bank_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (full_reg[rd_bank_reg]) state_next = FETCH;
      FETCH:   state_next = PRESENT;
      PRESENT: if (i_READY) state_next = (rd_idx_reg == LAST_IDX) ? IDLE : FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Registered array read doubles as the output holding register
  always_ff @(posedge CLK) begin
    if (RST)
      rd_data_reg <= '0;
    else if (state_reg == FETCH)
      rd_data_reg <= mem[{rd_bank_reg, rd_idx_reg}];
  end

  always_comb begin
    o_VALID  = (state_reg == PRESENT);
    o_LAST   = o_VALID && (rd_idx_reg == LAST_IDX);
    o_INDEX  = rd_idx_reg;
    o_DATA_R = rd_data_reg[2*DWL-1:DWL];
    o_DATA_I = rd_data_reg[DWL-1:0];
  end

  assign o_OVERFLOW = overflow_reg;

`ifdef FFT_SINK_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge CLK) begin
    if (RST)
      drop_cnt_reg <= 8'd0;
    else if (drop_start && drop_cnt_reg != 8'hFF)
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
  end

  assign o_DROP_CNT = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_fft_frame_sink.sv
// Scoreboard bench for fft_frame_sink: stimulus pushes expected samples, a negedge monitor pops and compares.
module tb_fft_frame_sink;
  localparam int DWL = 16;
  localparam int AWL = 5;
  localparam int N   = 32;

  logic           CLK = 1'b0;
  logic           RST;
  logic           EN;
  logic [DWL-1:0] i_DATA_R;
  logic [DWL-1:0] i_DATA_I;
  logic           i_VALID;
  logic [DWL-1:0] o_DATA_R;
  logic [DWL-1:0] o_DATA_I;
  logic [AWL-1:0] o_INDEX;
  logic           o_LAST;
  logic           o_VALID;
  logic           i_READY;
  logic           o_OVERFLOW;
`ifdef FFT_SINK_DROP_CNT_EN
  logic [7:0]     o_DROP_CNT;
`endif

  fft_frame_sink #(.DWL(DWL), .AWL(AWL)) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .i_DATA_R(i_DATA_R), .i_DATA_I(i_DATA_I), .i_VALID(i_VALID),
    .o_DATA_R(o_DATA_R), .o_DATA_I(o_DATA_I), .o_INDEX(o_INDEX),
    .o_LAST(o_LAST), .o_VALID(o_VALID), .i_READY(i_READY),
    .o_OVERFLOW(o_OVERFLOW)
`ifdef FFT_SINK_DROP_CNT_EN
    , .o_DROP_CNT(o_DROP_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [DWL-1:0] r;
    logic [DWL-1:0] i;
    logic [AWL-1:0] idx;
    logic           last;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: pops on every handshake and checks hold-while-stalled
  logic        stall_prev = 1'b0;
  logic [37:0] held;
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("hold", {25'd0, o_VALID, o_DATA_R, o_DATA_I, o_INDEX, o_LAST}, {25'd0, 1'b1, held});
      if (o_VALID && i_READY) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected: got idx %0d data %0h/%0h required none", o_INDEX, o_DATA_R, o_DATA_I);
        end else begin
          e = sb.pop_front();
          check("sample", {26'd0, o_DATA_R, o_DATA_I, o_INDEX, o_LAST}, {26'd0, e});
        end
      end
      if (o_VALID && !i_READY) begin
        stall_prev = 1'b1;
        held = {o_DATA_R, o_DATA_I, o_INDEX, o_LAST};
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic send(input int base, input int count, input bit push);
    exp_t e;
    for (int k = 0; k < count; k++) begin
      EN       = 1'b1;
      i_VALID  = 1'b1;
      i_DATA_R = 16'(base + k);
      i_DATA_I = 16'(-(base + k));
      if (push) begin
        e.r = i_DATA_R; e.i = i_DATA_I; e.idx = 5'(k); e.last = (k == N - 1);
        sb.push_back(e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic idle();
    EN = 1'b0; i_VALID = 1'b0; i_DATA_R = '0; i_DATA_I = '0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge CLK); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d samples outstanding, required 0", name, sb.size());
      sb.delete();
    end
    // Long enough for a wrongly stored extra frame to surface as unexpected
    repeat (2 * N + 10) @(posedge CLK);
    #1;
    check({name, "_idle"}, 64'(o_VALID), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    RST = 1'b1; i_READY = 1'b1;
    idle();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_valid", 64'(o_VALID), 64'd0);
    check("rst_last", 64'(o_LAST), 64'd0);
    check("rst_index", 64'(o_INDEX), 64'd0);
    check("rst_data", {32'd0, o_DATA_R, o_DATA_I}, 64'd0);
    check("rst_ovf", 64'(o_OVERFLOW), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // Single frame with latency check
    send(0, N, 1'b1);
    idle();
    @(negedge CLK); check("lat_t1", 64'(o_VALID), 64'd0);
    @(negedge CLK); check("lat_t2", 64'(o_VALID), 64'd0);
    @(negedge CLK); check("lat_t3", 64'(o_VALID), 64'd1);
    check("lat_idx", 64'(o_INDEX), 64'd0);
    wait_drain("single", 200);
    check("single_ovf", 64'(o_OVERFLOW), 64'd0);

    // Random backpressure
    fork
      begin send(1000, N, 1'b1); idle(); end
      begin
        for (int c = 0; c < 200; c++) begin
          i_READY = 1'($urandom_range(0, 1));
          @(posedge CLK); #1;
        end
      end
    join
    i_READY = 1'b1;
    wait_drain("bp", 300);

    // Ping-pong: two frames held while stalled
    i_READY = 1'b0;
    send(0, N, 1'b1);
    send(100, N, 1'b1);
    idle();
    repeat (10) @(posedge CLK);
    #1;
    check("pp_present", {58'd0, o_VALID, o_INDEX}, {58'd0, 1'b1, 5'd0});
    check("pp_ovf", 64'(o_OVERFLOW), 64'd0);
    i_READY = 1'b1;
    wait_drain("pp", 300);

    // Overflow: third frame dropped
    i_READY = 1'b0;
    send(0, N, 1'b1);
    send(100, N, 1'b1);
    send(200, N, 1'b0);
    idle();
    repeat (3) @(posedge CLK);
    #1;
    check("ovf_flag", 64'(o_OVERFLOW), 64'd1);
`ifdef FFT_SINK_DROP_CNT_EN
    check("ovf_dropcnt", 64'(o_DROP_CNT), 64'd1);
`endif
    i_READY = 1'b1;
    wait_drain("ovf", 400);

    // Reset mid-frame while draining
    i_READY = 1'b1;
    send(300, N, 1'b1);
    send(400, 10, 1'b0);
    idle();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    sb.delete();
    check("mid_rst_valid", 64'(o_VALID), 64'd0);
    check("mid_rst_ovf", 64'(o_OVERFLOW), 64'd0);
    send(500, N, 1'b1);
    idle();
    wait_drain("post_rst", 200);

    // EN gating: only EN=1 beats are indexed and stored
    i_READY = 1'b1;
    for (int k = 0; k < 2 * N; k++) begin
      i_VALID = 1'b1;
      if (k % 2 == 1) begin
        EN = 1'b1;
        i_DATA_R = 16'(600 + k / 2);
        i_DATA_I = 16'(-(600 + k / 2));
        e.r = i_DATA_R; e.i = i_DATA_I; e.idx = 5'(k / 2); e.last = (k / 2 == N - 1);
        sb.push_back(e);
      end else begin
        EN = 1'b0;
        i_DATA_R = 16'h7777;
        i_DATA_I = 16'h7777;
      end
      @(posedge CLK); #1;
    end
    idle();
    wait_drain("en_gate", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
